// File: rtl/serial_adder_if.sv
// serial_adder_if: start/operand/result bundle for the bit-serial adder.
// The i_subtract wire exists only when SERIAL_ADDER_SUBTRACT_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_augend;
  logic [WIDTH-1:0] i_addend;
`ifdef SERIAL_ADDER_SUBTRACT_EN
  logic             i_subtract;
`endif
  logic             o_ready;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;

  modport master (
`ifdef SERIAL_ADDER_SUBTRACT_EN
    output i_subtract,
`endif
    output i_start, i_augend, i_addend,
    input  o_ready, o_busy, o_done, o_sum, o_carry
  );

  modport slave (
`ifdef SERIAL_ADDER_SUBTRACT_EN
    input  i_subtract,
`endif
    input  i_start, i_augend, i_addend,
    output o_ready, o_busy, o_done, o_sum, o_carry
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock
// through a 1-bit full-adder cell with a registered carry.
// Optional feature macro: SERIAL_ADDER_SUBTRACT_EN (adds i_subtract; the
// addend is inverted and the carry seeded with 1 to form a - b).

// Single-bit full-adder cell.
module serial_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           i_clock,
  input  logic           i_reset_n,
  serial_adder_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_sum;
  logic             r_carry, r_cout;
  logic [CW-1:0]    r_cnt;

  logic             w_ready, w_accept, w_last;
  logic             w_s, w_c, w_cin_ld;
  logic [WIDTH-1:0] w_b_ld, w_acc_nxt;

  assign w_ready  = (r_state != S_RUN);
  assign w_accept = w_ready & bus.i_start;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUBTRACT_EN
  // Two's-complement subtract: a + ~b + 1, the +1 entering as initial carry.
  assign w_b_ld   = bus.i_subtract ? ~bus.i_addend : bus.i_addend;
  assign w_cin_ld = bus.i_subtract;
`else
  assign w_b_ld   = bus.i_addend;
  assign w_cin_ld = 1'b0;
`endif

  serial_adder_cell u_cell (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_acc1
      assign w_acc_nxt = w_s;
    end else begin : g_accn
      assign w_acc_nxt = {w_s, r_acc[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next state: RUN for WIDTH edges, one DONE cycle, starts taken in IDLE/DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)      w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = bus.i_start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per RUN edge, publish on the last.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.i_augend;
      r_b     <= w_b_ld;
      r_carry <= w_cin_ld;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_acc   <= w_acc_nxt;
      r_carry <= w_c;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_acc_nxt;
        r_cout <= w_c;
      end
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_busy  = (r_state == S_RUN);
  assign bus.o_done  = (r_state == S_DONE);
  assign bus.o_sum   = r_sum;
  assign bus.o_carry = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench. Issuers push expected {carry,sum};
// per-DUT monitors pop and compare on every o_done.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.i_clock(clk), .i_reset_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(4)) u_dut4 (.i_clock(clk), .i_reset_n(rst_n), .bus(bus4));

  int n_chk  = 0;
  int n_pass = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_to(input string name);
    n_chk++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitors: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (bus8.o_done) begin
      if (q8.size() == 0) fail_to("w8 unexpected done");
      else chk("w8 result", {23'd0, bus8.o_carry, bus8.o_sum}, {23'd0, q8.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (bus4.o_done) begin
      if (q4.size() == 0) fail_to("w4 unexpected done");
      else chk("w4 result", {27'd0, bus4.o_carry, bus4.o_sum}, {27'd0, q4.pop_front()});
    end
  end

  // Present a start once ready; returns at the negedge after the accept edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic [8:0] exp, input bit push);
    int t = 0;
    @(negedge clk);
    while (!bus8.o_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail_to("w8 ready");
    bus8.i_start = 1'b1; bus8.i_augend = a; bus8.i_addend = b;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    bus8.i_subtract = sub;
`endif
    if (sub) begin end
    if (push) q8.push_back(exp);
    @(negedge clk);
    bus8.i_start = 1'b0; bus8.i_augend = 8'hC3; bus8.i_addend = 8'h5E;
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic sub,
                        input logic [4:0] exp);
    int t = 0;
    @(negedge clk);
    while (!bus4.o_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail_to("w4 ready");
    bus4.i_start = 1'b1; bus4.i_augend = a; bus4.i_addend = b;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    bus4.i_subtract = sub;
`endif
    if (sub) begin end
    q4.push_back(exp);
    @(negedge clk);
    bus4.i_start = 1'b0; bus4.i_augend = 4'h9; bus4.i_addend = 4'h6;
  endtask

  initial begin
    int bc;
    int t;
    logic [4:0] e4;
    bus8.i_start = 1'b0; bus8.i_augend = '0; bus8.i_addend = '0;
    bus4.i_start = 1'b0; bus4.i_augend = '0; bus4.i_addend = '0;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    bus8.i_subtract = 1'b0; bus4.i_subtract = 1'b0;
`endif
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst ready", {31'd0, bus8.o_ready}, 32'd1);
    chk("rst busy",  {31'd0, bus8.o_busy},  32'd0);
    chk("rst done",  {31'd0, bus8.o_done},  32'd0);
    chk("rst sum",   {23'd0, bus8.o_carry, bus8.o_sum}, 32'd0);
    rst_n = 1'b1;

    // 0x5A + 0x3C: busy for 8 cycles, done for exactly one.
    issue8(8'h5A, 8'h3C, 1'b0, 9'h096, 1'b1);
    bc = 0;
    while (!bus8.o_done && bc < 50) begin
      if (bus8.o_busy) bc++;
      @(negedge clk);
    end
    chk("busy cycles", bc, 32'd8);
    @(negedge clk);
    chk("done single pulse", {31'd0, bus8.o_done}, 32'd0);

    // Carry-out cases.
    issue8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
    issue8(8'hFF, 8'hFF, 1'b0, 9'h1FE, 1'b1);

    // Back-to-back start in DONE, then an ignored mid-RUN start.
    issue8(8'h10, 8'h20, 1'b0, 9'h030, 1'b1);
    issue8(8'h01, 8'h02, 1'b0, 9'h003, 1'b1);
    repeat (2) @(negedge clk);
    chk("sum held in run", {23'd0, bus8.o_carry, bus8.o_sum}, 32'h030);
    bus8.i_start = 1'b1; bus8.i_augend = 8'h77; bus8.i_addend = 8'h77;
    @(negedge clk);
    bus8.i_start = 1'b0;
    chk("busy after mid start", {31'd0, bus8.o_busy}, 32'd1);
    chk("sum held late run", {23'd0, bus8.o_carry, bus8.o_sum}, 32'h030);
    repeat (12) @(negedge clk);
    chk("idle after ignored start", {31'd0, bus8.o_busy}, 32'd0);

    // Reset on edge 4 of a run aborts it: no done, outputs cleared.
    issue8(8'hAA, 8'h55, 1'b0, 9'h0FF, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort sum",   {23'd0, bus8.o_carry, bus8.o_sum}, 32'd0);
    chk("abort ready", {31'd0, bus8.o_ready}, 32'd1);
    chk("abort busy",  {31'd0, bus8.o_busy},  32'd0);
    repeat (12) @(negedge clk);
    issue8(8'h01, 8'h01, 1'b0, 9'h002, 1'b1);

`ifdef SERIAL_ADDER_SUBTRACT_EN
    issue8(8'h10, 8'h20, 1'b1, 9'h0F0, 1'b1);
    issue8(8'h20, 8'h10, 1'b1, 9'h110, 1'b1);
    issue8(8'h42, 8'h42, 1'b1, 9'h100, 1'b1);
`endif

    // WIDTH=4 exhaustive against a 5-bit reference.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        e4 = 5'(a + b);
        issue4(4'(a), 4'(b), 1'b0, e4);
`ifdef SERIAL_ADDER_SUBTRACT_EN
        e4 = {(a >= b), 4'(a - b)};
        issue4(4'(a), 4'(b), 1'b1, e4);
`endif
      end
    end

    // Drain both scoreboards.
    t = 0;
    while ((q8.size() != 0 || q4.size() != 0) && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) fail_to("drain");
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder built around a 1-bit adder stage with a registered carry. It captures two WIDTH-bit operands on a start handshake, processes them LSB-first over WIDTH cycles, and then presents the full-width sum and carry-out. It sits directly upstream of the register file and ALU result path, and it is the multi-bit consumer of the single-bit adder cell.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 1..32.
- `i_clock` input 1: sole clock, rising edge.
- `i_reset_n` input 1: reset, synchronous, active-low.
- `i_start` input 1: request a new operation; accepted only when `o_ready` = 1.
- `i_augend` input WIDTH: first operand, sampled only on the accept edge.
- `i_addend` input WIDTH: second operand, sampled only on the accept edge.
- `i_subtract` input 1: present only with `SERIAL_ADDER_SUBTRACT_EN`; sampled on the accept edge.
- `o_ready` output 1: block can accept `i_start` this cycle.
- `o_busy` output 1: serial operation in progress.
- `o_done` output 1: one-cycle pulse; new result is valid.
- `o_sum` output WIDTH: registered result.
- `o_carry` output 1: registered carry-out.

## Operation
- There are three states: IDLE, RUN and DONE.
- Outputs decode from state:
  - `o_ready` = (IDLE or DONE).
  - `o_busy` = RUN.
  - `o_done` = DONE.
- Accept: on an edge with `o_ready` & `i_start`:
  - The block loads the augend and addend shift registers and clears the bit counter.
  - The carry flip-flop is set to 0, or to 1 for subtract.
  - State goes to RUN.
- RUN, each edge:
  - The bit-0 adder cell takes A[0], B[0] and the carry flip-flop and produces sum and carry.
  - The sum bit shifts into the MSB of the internal result register.
  - Both operand registers shift right by one.
  - The carry flip-flop takes the new carry, and the counter increments.
- On the edge that processes bit WIDTH-1:
  - The internal result is copied to `o_sum`, and the final carry to `o_carry`.
  - State goes to DONE.
- DONE lasts one cycle. On the next edge:
  - An accepted start goes to RUN (back-to-back operation).
  - Otherwise the state goes to IDLE.
- `i_start` while in RUN is ignored. It is not queued.
- `o_sum`/`o_carry` hold the previous result throughout RUN. They change only on the completion edge or on reset.
- Arithmetic:
  - `{o_carry, o_sum}` = `i_augend` + `i_addend`, exact to WIDTH+1 bits.
  - Wrap-around is mod 2^WIDTH with the carry in `o_carry`.
- Inputs may change freely after the accept edge without affecting the result.
- WIDTH = 1: RUN lasts exactly one edge.

## Timing
- Reset: an edge with `i_reset_n` = 0 forces:
  - State IDLE, counter 0, carry flip-flop 0.
  - `o_sum` = 0, `o_carry` = 0.
- Outputs after a reset edge: `o_ready` = 1, `o_busy` = 0, `o_done` = 0.
- Reset has priority over start.
- Reset asserted during RUN aborts the operation. No `o_done` is produced, and `o_sum` is cleared.
- Latency, with accept on edge 0:
  - `o_busy` = 1 from after edge 0 through edge WIDTH.
  - `o_sum`/`o_carry` update on edge WIDTH.
  - `o_done` = 1 in the cycle between edges WIDTH and WIDTH+1.
- Throughput: one result per WIDTH+1 cycles with continuous starts, since a start is accepted in DONE.
- All outputs are registered or decoded directly from state flops. There is no combinational path from any input to any output.

## Configuration
- `SERIAL_ADDER_SUBTRACT_EN` defined:
  - The `i_subtract` port exists.
  - When `i_subtract` = 1 at accept, the block inverts the addend before loading and sets the initial carry to 1.
  - Result: `o_sum` = (augend - addend) mod 2^WIDTH, and `o_carry` = 1 iff augend >= addend (unsigned, no borrow).
  - When `i_subtract` = 0, behaviour is identical to add.
- `SERIAL_ADDER_SUBTRACT_EN` not defined:
  - The `i_subtract` port and inversion logic are absent.
  - The initial carry is always 0.

## Test plan
- WIDTH=8, 0x5A + 0x3C -> after edge 8: `o_sum` = 0x96, `o_carry` = 0. `o_done` pulses exactly one cycle, and `o_busy` is high for 8 cycles.
- WIDTH=8, 0xFF + 0x01 -> `o_sum` = 0x00, `o_carry` = 1. Repeat 0xFF + 0xFF -> 0xFE, carry 1.
- Start 0x10 + 0x20, then hold `i_start` high in DONE with 0x01 + 0x02. Also pulse `i_start` with 0x77 + 0x77 mid-RUN. Required: results 0x30, then 0x03 after another 8 edges; the mid-RUN start is ignored; `o_sum` stays 0x30 during the second RUN.
- Accept 0xAA + 0x55, then assert `i_reset_n` = 0 on edge 4 -> `o_sum` = 0, `o_carry` = 0, `o_ready` = 1, and no `o_done`. A new 0x01 + 0x01 gives 0x02 normally.
- With `SERIAL_ADDER_SUBTRACT_EN`, WIDTH=8:
  - 0x10 - 0x20 -> 0xF0, carry 0.
  - 0x20 - 0x10 -> 0x10, carry 1.
  - 0x42 - 0x42 -> 0x00, carry 1.
- WIDTH=4 exhaustive: all 256 operand pairs (plus both subtract modes when enabled) checked against a reference sum of WIDTH+1 bits.
